// File: rtl/dallanma_cozum_kuyrugu.sv
// Branch resolution queue: holds in-flight predictions in program order and reports
// outcome / misprediction. Optional DALLANMA_ISTATISTIK_EN adds resolve/mispredict counters.
module dallanma_cozum_kuyrugu #(
  parameter int unsigned DERINLIK = 4,
  parameter int unsigned PC_W     = 32
) (
  input  logic                          i_saat,
  input  logic                          i_reset,
  input  logic                          i_ongoru_gecerli,
  input  logic                          i_ongoru,
  input  logic [PC_W-1:0]               i_ongoru_pc,
  input  logic [PC_W-1:0]               i_ongoru_hedef,
  output logic                          o_kuyruk_dolu,
  output logic                          o_kuyruk_bos,
  output logic [$clog2(DERINLIK):0]     o_doluluk,
  input  logic                          i_cozum_gecerli,
  input  logic                          i_gercek_atladi,
  input  logic [PC_W-1:0]               i_gercek_hedef,
  output logic                          o_buyruk_atladi,
  output logic                          o_guncelle_gecerli,
  output logic                          o_ongoru_yanlis,
  output logic [PC_W-1:0]               o_duzeltme_pc,
`ifdef DALLANMA_ISTATISTIK_EN
  output logic [31:0]                   o_toplam_dallanma,
  output logic [31:0]                   o_yanlis_sayisi,
`endif
  output logic                          o_hata
);

  localparam int unsigned AW = $clog2(DERINLIK);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {CALIS, TEMIZLE} durum_t;

  durum_t          durum, sonraki_durum;
  logic [AW-1:0]   bas, kuyruk;
  logic [CW-1:0]   sayac;

  logic            ongoru_m [DERINLIK];
  logic [PC_W-1:0] pc_m     [DERINLIK];
  logic [PC_W-1:0] hedef_m  [DERINLIK];

  logic            bas_ongoru;
  logic [PC_W-1:0] bas_pc, bas_hedef, duzeltme;
  logic            cek, alt_tasma, ust_tasma, yanlis, temizle, yaz, yer_var;

  always_comb begin
    bas_ongoru    = ongoru_m[bas];
    bas_pc        = pc_m[bas];
    bas_hedef     = hedef_m[bas];
    cek           = i_cozum_gecerli & (sayac != '0);
    alt_tasma     = i_cozum_gecerli & (sayac == '0);
    yanlis        = (bas_ongoru != i_gercek_atladi) |
                    (bas_ongoru & i_gercek_atladi & (bas_hedef != i_gercek_hedef));
    temizle       = cek & yanlis;
    // A same-cycle pop frees a slot, so the full check uses the post-pop count.
    yer_var       = (sayac - CW'(cek)) < CW'(DERINLIK);
    yaz           = i_ongoru_gecerli & (durum == CALIS) & yer_var & ~temizle;
    ust_tasma     = i_ongoru_gecerli & (durum == CALIS) & ~yer_var;
    duzeltme      = i_gercek_atladi ? i_gercek_hedef : bas_pc + PC_W'(4);
    sonraki_durum = temizle ? TEMIZLE : CALIS;
  end

  always_ff @(posedge i_saat or negedge i_reset) begin
    if (!i_reset) begin
      durum              <= CALIS;
      bas                <= '0;
      kuyruk             <= '0;
      sayac              <= '0;
      o_guncelle_gecerli <= 1'b0;
      o_buyruk_atladi    <= 1'b0;
      o_ongoru_yanlis    <= 1'b0;
      o_duzeltme_pc      <= '0;
      o_hata             <= 1'b0;
    end else begin
      durum              <= sonraki_durum;
      o_guncelle_gecerli <= cek;
      o_buyruk_atladi    <= cek & i_gercek_atladi;
      o_ongoru_yanlis    <= temizle;
      o_duzeltme_pc      <= temizle ? duzeltme : '0;
      if (ust_tasma | alt_tasma) o_hata <= 1'b1;
      if (temizle) begin
        bas   <= kuyruk;
        sayac <= '0;
      end else begin
        bas    <= bas + AW'(cek);
        kuyruk <= kuyruk + AW'(yaz);
        sayac  <= sayac + CW'(yaz) - CW'(cek);
      end
    end
  end

  always_ff @(posedge i_saat) begin
    if (yaz) begin
      ongoru_m[kuyruk] <= i_ongoru;
      pc_m[kuyruk]     <= i_ongoru_pc;
      hedef_m[kuyruk]  <= i_ongoru_hedef;
    end
  end

`ifdef DALLANMA_ISTATISTIK_EN
  always_ff @(posedge i_saat or negedge i_reset) begin
    if (!i_reset) begin
      o_toplam_dallanma <= '0;
      o_yanlis_sayisi   <= '0;
    end else if (cek) begin
      if (o_toplam_dallanma != '1) o_toplam_dallanma <= o_toplam_dallanma + 32'd1;
      if (yanlis && o_yanlis_sayisi != '1) o_yanlis_sayisi <= o_yanlis_sayisi + 32'd1;
    end
  end
`endif

  assign o_kuyruk_dolu = (sayac == CW'(DERINLIK));
  assign o_kuyruk_bos  = (sayac == '0);
  assign o_doluluk     = sayac;

endmodule
